card_shoe: RTL and testbench

Finite, pseudo-randomly drawn card source that feeds the baccarat round controller. Each single-cycle `draw` request from the dealing side is answered with one rank (1..13) and a `card_valid` pulse; the shoe holds `4*DECKS` copies of each rank and never repeats a card until reshuffled. This block is the supplying end of the card-load interface: the round controller's load strobes are ORed into `draw`, and `card_out` feeds the card registers.

---
 rtl/card_pkg.sv | 23 ++
 rtl/lfsr16.sv | 29 ++
 rtl/card_shoe.sv | 175 +++++++++++++++++
 tb/tb_card_shoe.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/card_pkg.sv
// Purpose : shared rank type, shoe constants and FSM encoding for the card path.
// Latency : n/a (types, constants and one pure function only).
// Backpres: n/a. Also imported by the round controller so both ends agree on rank_t.
package card_pkg;

    typedef logic [3:0] rank_t;

    localparam rank_t       RANK_NONE = 4'd0;
    localparam rank_t       RANK_MAX  = 4'd13;
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PICK = 2'd1,
        SCAN = 2'd2
    } state_t;

    // One step of the right-shifting Galois LFSR.
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_MASK : 16'h0000);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Purpose : free-running 16-bit Galois LFSR used as the card candidate source.
// Latency : advances one step on every rising edge; q is a register.
// Backpres: none, never stalls. Ports: slow_clock, resetb (async low), seed, q.
module lfsr16
    import card_pkg::*;
(
    input  logic        slow_clock,
    input  logic        resetb,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] r_q;
    logic [15:0] w_seed_safe;

    // All-zero is the lock-up state of this LFSR, so a zero seed is nudged to 1.
    assign w_seed_safe = (seed == 16'h0000) ? 16'h0001 : seed;

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            r_q <= w_seed_safe;
        end else begin
            r_q <= lfsr_next(r_q);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/card_shoe.sv
// Purpose : finite shoe of 4*DECKS copies per rank, dealt pseudo-randomly on draw.
// Latency : draw at edge k -> accept at edge k+1..k+29; all outputs registered.
// Backpres: draws while busy are dropped (not queued); shuffle overrides everything.
// Ports   : slow_clock, resetb, draw, shuffle -> card_out, card_valid, busy,
//           shoe_empty, cards_left.
module card_shoe
    import card_pkg::*;
#(
    parameter int          DECKS = 1,
    parameter logic [15:0] SEED  = 16'hACE1
)(
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic       draw,
    input  logic       shuffle,
    output rank_t      card_out,
    output logic       card_valid,
    output logic       busy,
    output logic       shoe_empty,
    output logic [9:0] cards_left
);

    localparam int            CW        = $clog2(4*DECKS+1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(4*DECKS);
    localparam logic [9:0]    LEFT_FULL = 10'(52*DECKS);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt [1:13];
    logic [9:0]    r_left;
    logic [3:0]    r_retry;
    rank_t         r_scan;
    rank_t         r_card;
    logic          r_valid;
    logic          r_busy;
    logic          r_empty;

    logic [15:0]   w_lfsr;
    logic [15:0]   w_avail;
    rank_t         w_cand;
    logic          w_accept;
    logic          w_start;
    logic          w_empty_draw;
    rank_t         w_acc_rank;
    logic          w_unused_lfsr;

    lfsr16 u_lfsr (
        .slow_clock (slow_clock),
        .resetb     (resetb),
        .seed       (SEED),
        .q          (w_lfsr)
    );

    assign w_cand = w_lfsr[3:0];
    // Upper LFSR bits only matter for the shift chain inside lfsr16.
    assign w_unused_lfsr = ^w_lfsr[15:4];

    // Availability per rank code; codes 0, 14 and 15 stay 0 so out-of-range
    // candidates are rejected by the same lookup as exhausted ranks.
    always_comb begin
        w_avail = '0;
        for (int r = 1; r <= 13; r++) begin
            w_avail[r] = (r_cnt[r] != '0);
        end
    end

    // FSM: state register
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        if (shuffle) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: if (draw && r_left != 10'd0) w_state_nxt = PICK;
                PICK: begin
                    if (w_avail[w_cand])        w_state_nxt = IDLE;
                    else if (r_retry == 4'd15)  w_state_nxt = SCAN;
                end
                SCAN: if (w_avail[r_scan]) w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // FSM: per-cycle decisions consumed by the datapath registers
    always_comb begin
        w_accept     = 1'b0;
        w_acc_rank   = RANK_NONE;
        w_start      = 1'b0;
        w_empty_draw = 1'b0;
        if (!shuffle) begin
            case (r_state)
                IDLE: begin
                    w_start      = draw && (r_left != 10'd0);
                    w_empty_draw = draw && (r_left == 10'd0);
                end
                PICK: if (w_avail[w_cand]) begin
                    w_accept   = 1'b1;
                    w_acc_rank = w_cand;
                end
                SCAN: if (w_avail[r_scan]) begin
                    w_accept   = 1'b1;
                    w_acc_rank = r_scan;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            for (int r = 1; r <= 13; r++) r_cnt[r] <= CNT_FULL;
            r_left  <= LEFT_FULL;
            r_retry <= 4'd0;
            r_scan  <= 4'd1;
            r_card  <= RANK_NONE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_empty <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (shuffle) begin
                for (int r = 1; r <= 13; r++) r_cnt[r] <= CNT_FULL;
                r_left  <= LEFT_FULL;
                r_card  <= RANK_NONE;
                r_busy  <= 1'b0;
                r_empty <= 1'b0;
            end else begin
                if (w_start) begin
                    r_busy  <= 1'b1;
                    r_retry <= 4'd0;
                end
                if (w_empty_draw) begin
                    r_card  <= RANK_NONE;
                    r_valid <= 1'b1;
                end
                // Every PICK reject preloads the scan start, so the 16th one
                // hands SCAN a fresh rank 1.
                if (r_state == PICK && !w_accept) begin
                    r_retry <= r_retry + 4'd1;
                    r_scan  <= 4'd1;
                end
                if (r_state == SCAN && !w_accept) begin
                    r_scan <= (r_scan == RANK_MAX) ? 4'd1 : r_scan + 4'd1;
                end
                if (w_accept) begin
                    for (int r = 1; r <= 13; r++) begin
                        if (w_acc_rank == 4'(r)) r_cnt[r] <= r_cnt[r] - CW'(1);
                    end
                    r_left  <= r_left - 10'd1;
                    r_empty <= (r_left == 10'd1);
                    r_card  <= w_acc_rank;
                    r_valid <= 1'b1;
                    r_busy  <= 1'b0;
                end
            end
        end
    end

    assign card_out   = r_card;
    assign card_valid = r_valid;
    assign busy       = r_busy;
    assign shoe_empty = r_empty;
    assign cards_left = r_left;

endmodule

// File: tb/tb_card_shoe.sv
// Purpose : directed self-checking bench for card_shoe (DECKS=1 default seed,
//           plus a DECKS=2 instance with a zero seed).
// Latency : expected ranks and accept edges come from an independent LFSR/shoe model.
// Backpres: exercises dropped draws while busy and shuffle aborts.
module tb_card_shoe;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetb, draw, shuffle, draw0, shuffle0;
    logic [3:0] card_out, card_out0;
    logic       card_valid, busy, shoe_empty;
    logic       v0, b0, e0;
    logic [9:0] cards_left, left0;

    card_shoe #(.DECKS(1)) dut (
        .slow_clock (clk),
        .resetb     (resetb),
        .draw       (draw),
        .shuffle    (shuffle),
        .card_out   (card_out),
        .card_valid (card_valid),
        .busy       (busy),
        .shoe_empty (shoe_empty),
        .cards_left (cards_left)
    );

    card_shoe #(.DECKS(2), .SEED(16'h0000)) dut0 (
        .slow_clock (clk),
        .resetb     (resetb),
        .draw       (draw0),
        .shuffle    (shuffle0),
        .card_out   (card_out0),
        .card_valid (v0),
        .busy       (b0),
        .shoe_empty (e0),
        .cards_left (left0)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cnt   [1:13];
    int          tally [1:13];
    int          left;
    logic [15:0] m1, m0;

    function automatic logic [15:0] step(input logic [15:0] v);
        logic [15:0] s;
        s = {1'b0, v[15:1]};
        if (v[0]) s = s ^ 16'hB400;
        return s;
    endfunction

    // Reference LFSRs: seed ACE1 for dut, zero seed (becomes 1) for dut0.
    always @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            m1 <= 16'hACE1;
            m0 <= 16'h0001;
        end else begin
            m1 <= step(m1);
            m0 <= step(m0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
    endtask

    task automatic fill(input int per_rank, input int total);
        for (int r = 1; r <= 13; r++) cnt[r] = per_rank;
        left = total;
    endtask

    // Given the LFSR value seen in the first PICK cycle, predict the dealt
    // rank and how many edges after the draw edge the accept lands.
    task automatic predict(input logic [15:0] l0, output int rank, output int n);
        logic [15:0] l;
        int          c;
        l = l0; rank = 0; n = 0;
        for (int t = 0; t < 16 && rank == 0; t++) begin
            n++;
            c = int'(l[3:0]);
            if (c >= 1 && c <= 13) begin
                if (cnt[c] > 0) rank = c;
            end
            l = step(l);
        end
        for (int s = 1; s <= 13 && rank == 0; s++) begin
            n++;
            if (cnt[s] > 0) rank = s;
        end
    endtask

    // Issue one draw on dut (sel=0) or dut0 (sel=1) and check the outcome.
    task automatic do_draw(input bit sel, input string tag, output int got);
        int          er, en, n;
        logic [15:0] l;
        l = step(sel ? m0 : m1);
        if (left > 0) predict(l, er, en);
        else begin er = 0; en = 0; end
        if (sel) draw0 = 1'b1; else draw = 1'b1;
        @(posedge clk); #1;
        draw = 1'b0; draw0 = 1'b0;
        if (left > 0) chk({tag, " busy"}, sel ? b0 : busy, 1);
        n = 0;
        while (!(sel ? v0 : card_valid) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, " latency"}, n, en);
        chk({tag, " rank"}, sel ? card_out0 : card_out, er);
        if (er != 0) begin
            cnt[er]--;
            left--;
            if (!sel) tally[er]++;
        end
        chk({tag, " left"}, sel ? left0 : cards_left, left);
        chk({tag, " idle"}, sel ? b0 : busy, 0);
        got = er;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int er, en, w, nv, got, distinct;
        int seq_a [6];
        int seq_b [6];

        resetb = 1'b1; draw = 1'b0; shuffle = 1'b0; draw0 = 1'b0; shuffle0 = 1'b0;
        for (int r = 1; r <= 13; r++) tally[r] = 0;

        // Asynchronous reset, checked before any clock edge.
        #1 resetb = 1'b0;
        #1;
        chk("rst cards_left", cards_left, 52);
        chk("rst card_out", card_out, 0);
        chk("rst busy", busy, 0);
        chk("rst shoe_empty", shoe_empty, 0);
        chk("rst card_valid", card_valid, 0);
        chk("rst dut0 cards_left", left0, 104);
        @(posedge clk); #1 resetb = 1'b1;
        @(posedge clk); #1;
        chk("post-rst cards_left", cards_left, 52);
        chk("post-rst card_valid", card_valid, 0);

        // Deal out the whole shoe.
        fill(4, 52);
        for (int i = 0; i < 52; i++) do_draw(1'b0, "deal", got);
        for (int r = 1; r <= 13; r++) chk($sformatf("tally rank %0d", r), tally[r], 4);
        chk("full deal shoe_empty", shoe_empty, 1);

        // Draw from an empty shoe: immediate pulse with rank 0.
        do_draw(1'b0, "empty", got);
        @(posedge clk); #1;
        chk("empty valid drops", card_valid, 0);
        chk("empty still empty", shoe_empty, 1);

        // Refill.
        shuffle = 1'b1;
        @(posedge clk); #1 shuffle = 1'b0;
        chk("refill left", cards_left, 52);
        chk("refill shoe_empty", shoe_empty, 0);
        chk("refill card_out", card_out, 0);
        fill(4, 52);

        // Draw held 3 cycles: wait until the first try is predicted to miss so
        // the third draw edge cannot fall into IDLE.
        w = 0;
        predict(step(m1), er, en);
        while (en < 2 && w < 200) begin
            @(posedge clk); #1;
            w++;
            predict(step(m1), er, en);
        end
        chk("held-draw setup bound", (en >= 2), 1);
        nv = 0; got = 0;
        draw = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (card_valid) begin nv++; got = card_out; end
        end
        draw = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (card_valid) begin nv++; got = card_out; end
        end
        chk("held-draw pulses", nv, 1);
        chk("held-draw rank", got, er);
        chk("held-draw left", cards_left, 51);
        if (er != 0) cnt[er]--;
        left--;

        // Shuffle while in PICK aborts the draw.
        draw = 1'b1;
        @(posedge clk); #1 draw = 1'b0;
        chk("abort busy in PICK", busy, 1);
        shuffle = 1'b1;
        @(posedge clk); #1 shuffle = 1'b0;
        chk("abort valid", card_valid, 0);
        chk("abort left", cards_left, 52);
        chk("abort busy", busy, 0);
        chk("abort card_out", card_out, 0);
        nv = 0;
        for (int i = 0; i < 35; i++) begin
            @(posedge clk); #1;
            if (card_valid) nv++;
        end
        chk("abort no late pulse", nv, 0);

        // Draw and shuffle on the same edge.
        draw = 1'b1; shuffle = 1'b1;
        @(posedge clk); #1;
        draw = 1'b0; shuffle = 1'b0;
        chk("same-edge busy", busy, 0);
        chk("same-edge valid", card_valid, 0);
        nv = 0;
        for (int i = 0; i < 35; i++) begin
            @(posedge clk); #1;
            if (card_valid) nv++;
        end
        chk("same-edge no pulse", nv, 0);
        chk("same-edge left", cards_left, 52);
        fill(4, 52);

        // Reset asserted mid-draw.
        do_draw(1'b0, "pre-reset", got);
        draw = 1'b1;
        @(posedge clk); #1 draw = 1'b0;
        chk("mid-draw busy", busy, 1);
        #2 resetb = 1'b0;
        #1;
        chk("mid-rst left", cards_left, 52);
        chk("mid-rst card_out", card_out, 0);
        chk("mid-rst busy", busy, 0);
        chk("mid-rst valid", card_valid, 0);
        chk("mid-rst shoe_empty", shoe_empty, 0);
        @(posedge clk); #1 resetb = 1'b1;

        // Zero seed, two decks: same sequence after each reset.
        fill(8, 104);
        chk("seed0 left", left0, 104);
        for (int i = 0; i < 6; i++) begin
            do_draw(1'b1, "seed0 run1", got);
            seq_a[i] = got;
        end
        resetb = 1'b0;
        @(posedge clk); #1 resetb = 1'b1;
        fill(8, 104);
        for (int i = 0; i < 6; i++) begin
            do_draw(1'b1, "seed0 run2", got);
            seq_b[i] = got;
        end
        distinct = 0;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("seed0 repeat %0d", i), seq_b[i], seq_a[i]);
            if (i > 0 && seq_a[i] != seq_a[0]) distinct++;
        end
        chk("seed0 not stuck", (distinct > 0), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
